// File: rtl/barramento_snooping_pkg.sv
// rtl/barramento_snooping_pkg.sv - shared bus message, FSM state and MSI codes
// Shared by the snooping bus controller and the cache MSI state machine.
package barramento_snooping_pkg;

  // Messages a cache places on the snooping bus.
  typedef enum logic [1:0] {
    MSG_INVALIDAR    = 2'b00,
    MSG_READ_MISS    = 2'b01,
    MSG_WRITE_MISS   = 2'b10,
    MSG_SEM_MENSAGEM = 2'b11
  } bus_msg_e;

  // Bus controller states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SNOOP     = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_MEMACCESS = 3'd3,
    ST_DONE      = 3'd4
  } bus_state_e;

  // Cache line states and processor operations used by the cache MSI machine.
  typedef enum logic [1:0] {
    MSI_INVALID  = 2'b00,
    MSI_SHARED   = 2'b01,
    MSI_MODIFIED = 2'b10
  } msi_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } cpu_op_e;

  // Index value meaning "no cache".
  localparam logic [1:0] NO_INDEX = 2'b11;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] v;
    v = 3'b000;
    if (idx != NO_INDEX) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] lowest_index(input logic [2:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return NO_INDEX;
  endfunction

  function automatic logic more_than_one(input logic [2:0] v);
    return (v & (v - 3'd1)) != 3'b000;
  endfunction

endpackage

// File: rtl/barramento_snooping_arbitro_rr.sv
// rtl/barramento_snooping_arbitro_rr.sv - three-way round-robin arbiter
// Purpose: pick the first requester after the last granted index.
// Ports: req[2:0] requests, pointer last granted index, grant chosen index (11 = none).
module arbitro_rr
  import barramento_snooping_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] pointer,
  output logic [1:0] grant
);

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0 = next_idx(pointer);
    c1 = next_idx(c0);
    c2 = next_idx(c1);
    grant = NO_INDEX;
    if (req[c0])      grant = c0;
    else if (req[c1]) grant = c1;
    else if (req[c2]) grant = c2;
  end

endmodule

// File: rtl/barramento_snooping.sv
// rtl/barramento_snooping.sv - snooping bus controller for three MSI caches
// Purpose: arbitrate cache requests, broadcast the message, run writeback or
//   memory access, and acknowledge the owner.
// Ports: clock/reset (async active-low); req, msg0-2, wb, abort, memReady in;
//   busMsg, busOwner, snoopValid, memRead, memWrite, dataOwner, ack, error out.
module barramento_snooping
  import barramento_snooping_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [1:0] msg0,
  input  logic [1:0] msg1,
  input  logic [1:0] msg2,
  input  logic [2:0] wb,
  input  logic [2:0] abort,
  input  logic       memReady,
  output logic [1:0] busMsg,
  output logic [1:0] busOwner,
  output logic [2:0] snoopValid,
  output logic       memRead,
  output logic       memWrite,
  output logic [1:0] dataOwner,
  output logic [2:0] ack,
  output logic       error
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  bus_state_e state_q, state_d;
  bus_msg_e   msg_q, msg_d, sel_msg;
  logic [1:0] owner_q, owner_d, ptr_q, ptr_d, grant;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] bus_msg_q, bus_msg_d, bus_owner_q, bus_owner_d;
  logic [1:0] data_owner_q, data_owner_d;
  logic [2:0] snoop_valid_q, snoop_valid_d, ack_q, ack_d;
  logic       mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic       error_q, error_d;
  logic [2:0] snoop_abort, snoop_wb_only;

  arbitro_rr u_arbitro_rr (
    .req     (req),
    .pointer (ptr_q),
    .grant   (grant)
  );

  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    data_owner_d = data_owner_q;
    error_d      = error_q;

    case (grant)
      2'd0:    sel_msg = bus_msg_e'(msg0);
      2'd1:    sel_msg = bus_msg_e'(msg1);
      default: sel_msg = bus_msg_e'(msg2);
    endcase

    // snoop_valid_q already excludes the owner, so the owner's wb/abort never count.
    snoop_abort   = abort & snoop_valid_q;
    snoop_wb_only = wb & ~abort & snoop_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (grant != NO_INDEX) begin
          owner_d = grant;
          msg_d   = sel_msg;
          state_d = (sel_msg == MSG_SEM_MENSAGEM) ? ST_DONE : ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (more_than_one(snoop_abort) || (snoop_wb_only != 3'b000)) error_d = 1'b1;
        cnt_d = 8'd0;
        if (msg_q == MSG_INVALIDAR) begin
          state_d = ST_DONE;
        end else if (snoop_abort != 3'b000) begin
          state_d      = ST_WRITEBACK;
          data_owner_d = lowest_index(snoop_abort);
        end else begin
          state_d = ST_MEMACCESS;
        end
      end
      ST_WRITEBACK, ST_MEMACCESS: begin
        if (memReady) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        ptr_d   = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered: decode them from the next state.
    if (state_d != ST_WRITEBACK) data_owner_d = NO_INDEX;
    bus_msg_d     = (state_d == ST_SNOOP) ? msg_d : MSG_SEM_MENSAGEM;
    bus_owner_d   = (state_d == ST_IDLE) ? NO_INDEX : owner_d;
    snoop_valid_d = (state_d == ST_SNOOP) ? ~onehot3(owner_d) : 3'b000;
    mem_read_d    = (state_d == ST_MEMACCESS);
    mem_write_d   = (state_d == ST_WRITEBACK);
    ack_d         = (state_d == ST_DONE) ? onehot3(owner_d) : 3'b000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      msg_q         <= MSG_SEM_MENSAGEM;
      owner_q       <= NO_INDEX;
      ptr_q         <= 2'd2;
      cnt_q         <= 8'd0;
      bus_msg_q     <= MSG_SEM_MENSAGEM;
      bus_owner_q   <= NO_INDEX;
      data_owner_q  <= NO_INDEX;
      snoop_valid_q <= 3'b000;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      ack_q         <= 3'b000;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      msg_q         <= msg_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      bus_msg_q     <= bus_msg_d;
      bus_owner_q   <= bus_owner_d;
      data_owner_q  <= data_owner_d;
      snoop_valid_q <= snoop_valid_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      ack_q         <= ack_d;
      error_q       <= error_d;
    end
  end

  assign busMsg     = bus_msg_q;
  assign busOwner   = bus_owner_q;
  assign snoopValid = snoop_valid_q;
  assign memRead    = mem_read_q;
  assign memWrite   = mem_write_q;
  assign dataOwner  = data_owner_q;
  assign ack        = ack_q;
  assign error      = error_q;

endmodule
